// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: blank pattern, hex segment
// table (active-low, bit 6 = a ... bit 0 = g) and a width helper.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

  // Bits needed to hold 0..n-1, never less than 1.
  function automatic int clog2_safe(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_hex_seg_decode.sv
// Combinational hex nibble to active-low 7-segment decoder.
module hex_seg_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nib];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver with frame-shadowed inputs and
// leading-zero blanking. Define SEG7_BLINK_EN to add per-digit blinking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [4*NUM_DIGITS-1:0]   digits,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic                      lz_blank,
`ifdef SEG7_BLINK_EN
  input  logic [NUM_DIGITS-1:0]     blink_mask,
`endif
  output logic [NUM_DIGITS-1:0]     an_n,
  output logic [6:0]                seg_n,
  output logic                      dp_n,
  output logic                      frame
);

  localparam int IW = clog2_safe(NUM_DIGITS);
  localparam int PW = clog2_safe(REFRESH_DIV);

  if (NUM_DIGITS < 2 || REFRESH_DIV < 2 || BLINK_DIV < 1) begin : g_param_check
    $error("seg7_scan_driver: illegal parameter values");
  end

  logic [PW-1:0]           presc;
  logic [IW-1:0]           idx;
  logic                    tick;
  logic                    wrap;
  logic [4*NUM_DIGITS-1:0] sh_digits;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic                    sh_lz;

  assign tick = (presc == PW'(REFRESH_DIV - 1));
  assign wrap = tick && (idx == IW'(NUM_DIGITS - 1));

  // Prescaler, scan index and frame-boundary shadow capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc     <= '0;
      idx       <= '0;
      sh_digits <= '0;
      sh_dp     <= '0;
      sh_lz     <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) idx <= wrap ? '0 : idx + 1'b1;
      if (wrap) begin
        sh_digits <= digits;
        sh_dp     <= dp_in;
        sh_lz     <= lz_blank;
      end
    end
  end

  // Leading-zero chain: stays set from the top digit down until a nonzero
  // digit or a lit decimal point is met; digit 0 is always shown.
  logic [NUM_DIGITS-1:0] lz_blk;
  always_comb begin
    logic run;
    lz_blk = '0;
    run    = sh_lz;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      run       = run && (sh_digits[4*k +: 4] == 4'h0) && !sh_dp[k];
      lz_blk[k] = run;
    end
  end

`ifdef SEG7_BLINK_EN
  localparam int BW = clog2_safe(BLINK_DIV);
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (wrap) begin
      if (blink_cnt == BW'(BLINK_DIV - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end
`endif

  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_lz;
  logic                  cur_blink;
  logic [NUM_DIGITS-1:0] cur_sel;

  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_lz    = 1'b0;
    cur_blink = 1'b0;
    cur_sel   = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (int'(idx) == k) begin
        cur_nib    = sh_digits[4*k +: 4];
        cur_dp     = sh_dp[k];
        cur_lz     = lz_blk[k];
        cur_sel[k] = 1'b1;
`ifdef SEG7_BLINK_EN
        cur_blink  = blink_phase && blink_mask[k];
`endif
      end
    end
  end

  logic [6:0] dec_seg;
  hex_seg_decode u_dec (
    .nib (cur_nib),
    .seg (dec_seg)
  );

  logic blank;
  assign blank = !en || cur_lz || cur_blink;

  // Output registers; the anode is forced off for one cycle after each tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_n  <= '1;
      seg_n <= SEG_BLANK;
      dp_n  <= 1'b1;
      frame <= 1'b0;
    end else begin
      an_n  <= (tick || blank) ? '1 : ~cur_sel;
      seg_n <= blank ? SEG_BLANK : dec_seg;
      dp_n  <= blank ? 1'b1 : ~cur_dp;
      frame <= wrap;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (NUM_DIGITS=4, REFRESH_DIV=4, BLINK_DIV=2).
module tb_seg7_scan_driver;

  localparam int N = 4;
  localparam int R = 4;
  localparam int B = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] digits = '0;
  logic [3:0]  dp_in = '0;
  logic        lz_blank = 1'b0;
  logic [3:0]  bm_v;
`ifdef SEG7_BLINK_EN
  logic [3:0]  blink_mask = '0;
  assign bm_v = blink_mask;
`else
  assign bm_v = 4'b0000;
`endif
  logic [3:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic        frame;

  seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLINK_DIV(B)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .digits     (digits),
    .dp_in      (dp_in),
    .lz_blank   (lz_blank),
`ifdef SEG7_BLINK_EN
    .blink_mask (blink_mask),
`endif
    .an_n       (an_n),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .frame      (frame)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } out_t;

  function automatic logic [6:0] ref_seg(input logic [3:0] v);
    case (v)
      4'h0: return 7'h01;  4'h1: return 7'h4F;  4'h2: return 7'h12;  4'h3: return 7'h06;
      4'h4: return 7'h4C;  4'h5: return 7'h24;  4'h6: return 7'h20;  4'h7: return 7'h0F;
      4'h8: return 7'h00;  4'h9: return 7'h04;  4'hA: return 7'h08;  4'hB: return 7'h60;
      4'hC: return 7'h31;  4'hD: return 7'h42;  4'hE: return 7'h30;  default: return 7'h38;
    endcase
  endfunction

  // Digit k is a leading zero when it and every digit above it read 0 with dp clear.
  function automatic bit ref_lz(input logic [15:0] d, input logic [3:0] dp, input bit lz, input int k);
    if (!lz || k == 0) return 1'b0;
    for (int j = k; j < N; j++)
      if (d[4*j +: 4] != 4'h0 || dp[j]) return 1'b0;
    return 1'b1;
  endfunction

  // Output after clock edge number n (counted from reset release).
  function automatic out_t model_out(input int n, input logic [15:0] sd, input logic [3:0] sdp,
                                     input bit slz, input int wraps, input bit en_v,
                                     input logic [3:0] bm);
    int   pos;
    int   di;
    bit   blank;
    out_t o;
    pos   = n % R;
    di    = (n / R) % N;
    blank = !en_v || ref_lz(sd, sdp, slz, di) || ((((wraps / B) % 2) == 1) && bm[di]);
    o.an  = (pos == R - 1 || blank) ? 4'hF : ~(4'b0001 << di);
    o.seg = blank ? 7'h7F : ref_seg(sd[4*di +: 4]);
    o.dp  = blank ? 1'b1 : ~sdp[di];
    return o;
  endfunction

  int          m_n;
  int          m_wraps;
  logic [15:0] m_sd;
  logic [3:0]  m_sdp;
  bit          m_slz;
  out_t        e_out;
  logic        e_frame;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_n     <= 0;
      m_wraps <= 0;
      m_sd    <= '0;
      m_sdp   <= '0;
      m_slz   <= 1'b0;
      e_out   <= '{an: 4'hF, seg: 7'h7F, dp: 1'b1};
      e_frame <= 1'b0;
    end else begin
      e_out   <= model_out(m_n, m_sd, m_sdp, m_slz, m_wraps, en, bm_v);
      e_frame <= ((m_n % (R * N)) == R * N - 1);
      if ((m_n % (R * N)) == R * N - 1) begin
        m_sd    <= digits;
        m_sdp   <= dp_in;
        m_slz   <= lz_blank;
        m_wraps <= m_wraps + 1;
      end
      m_n <= m_n + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    chk("mdl_an", an_n, e_out.an);
    chk("mdl_seg", seg_n, e_out.seg);
    chk("mdl_dp", dp_n, e_out.dp);
    chk("mdl_frame", frame, e_frame);
  endtask

  task automatic wait_frame();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      step();
      if (frame) seen = 1'b1;
    end
    if (!seen) chk("frame_timeout", 0, 1);
  endtask

  typedef struct {
    logic [3:0] nib;
    logic [6:0] seg;
  } dec_vec_t;

  dec_vec_t dec_tab [16];
  bit       lit [8];
  int       nlit;

  initial begin
    dec_tab = '{
      '{4'h0, 7'h01}, '{4'h1, 7'h4F}, '{4'h2, 7'h12}, '{4'h3, 7'h06},
      '{4'h4, 7'h4C}, '{4'h5, 7'h24}, '{4'h6, 7'h20}, '{4'h7, 7'h0F},
      '{4'h8, 7'h00}, '{4'h9, 7'h04}, '{4'hA, 7'h08}, '{4'hB, 7'h60},
      '{4'hC, 7'h31}, '{4'hD, 7'h42}, '{4'hE, 7'h30}, '{4'hF, 7'h38}
    };

    repeat (3) @(negedge clk);
    chk("rst_an", an_n, 4'hF);
    chk("rst_seg", seg_n, 7'h7F);
    rst_n = 1'b1;
    en    = 1'b1;
    step();
    chk("rel_first_an", an_n, 4'hE);

    // Reset mid-scan: outputs return at once, scan restarts at digit 0
    digits = 16'h12AF;
    repeat (7) step();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_an", an_n, 4'hF);
    chk("midrst_seg", seg_n, 7'h7F);
    chk("midrst_dp", dp_n, 1'b1);
    chk("midrst_frame", frame, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("midrst_first_an", an_n, 4'hE);

    // Full scan of 12AF with dead cycles and frame period
    wait_frame();
    for (int j = 1; j <= 16; j++) begin
      logic [3:0] an_tab  [4];
      logic [6:0] seg_tab [4];
      an_tab  = '{4'hE, 4'hD, 4'hB, 4'h7};
      seg_tab = '{7'h38, 7'h08, 7'h12, 7'h4F};
      step();
      if (j % 4 == 0) chk("scan_dead_an", an_n, 4'hF);
      else begin
        chk("scan_an", an_n, an_tab[(j - 1) / 4]);
        chk("scan_seg", seg_n, seg_tab[(j - 1) / 4]);
        chk("scan_dp", dp_n, 1'b1);
      end
      if (j == 8)  chk("scan_noframe", frame, 1'b0);
      if (j == 16) chk("scan_frame", frame, 1'b1);
    end

    // Decode table, digit 0
    for (int i = 0; i < 16; i++) begin
      digits = {4{dec_tab[i].nib}};
      wait_frame();
      step();
      chk("dec_an", an_n, 4'hE);
      chk("dec_seg", seg_n, dec_tab[i].seg);
    end

    // Leading-zero blanking
    lz_blank = 1'b1;
    digits   = 16'h0007;
    wait_frame();
    for (int j = 1; j <= 15; j++) begin
      step();
      if (j == 1) begin
        chk("lz_d0_an", an_n, 4'hE);
        chk("lz_d0_seg", seg_n, 7'h0F);
      end
      if (j == 5 || j == 9 || j == 13) begin
        chk("lz_dark_an", an_n, 4'hF);
        chk("lz_dark_seg", seg_n, 7'h7F);
        chk("lz_dark_dp", dp_n, 1'b1);
      end
    end
    dp_in = 4'b0100;
    wait_frame();
    for (int j = 1; j <= 15; j++) begin
      step();
      if (j == 5) begin
        chk("lzdp_d1_an", an_n, 4'hD);
        chk("lzdp_d1_seg", seg_n, 7'h01);
      end
      if (j == 9) begin
        chk("lzdp_d2_an", an_n, 4'hB);
        chk("lzdp_d2_seg", seg_n, 7'h01);
        chk("lzdp_d2_dp", dp_n, 1'b0);
      end
      if (j == 13) chk("lzdp_d3_an", an_n, 4'hF);
    end
    lz_blank = 1'b0;
    dp_in    = 4'b0000;

    // Mid-frame input change does not tear
    digits = 16'h1111;
    wait_frame();
    step();
    step();
    digits = 16'h2222;
    for (int j = 3; j <= 16; j++) begin
      step();
      if (j == 5 || j == 9 || j == 13) chk("tear_seg", seg_n, 7'h4F);
      if (j == 16) chk("tear_frame", frame, 1'b1);
    end
    step();
    chk("tear_next_an", an_n, 4'hE);
    chk("tear_next_seg", seg_n, 7'h12);

    // Display off: anodes dark, scanning continues underneath
    en = 1'b0;
    step();
    for (int i = 0; i < 10; i++) begin
      step();
      chk("en_off_an", an_n, 4'hF);
    end
    en = 1'b1;
    repeat (8) step();

`ifdef SEG7_BLINK_EN
    digits     = 16'h1234;
    blink_mask = 4'b0001;
    wait_frame();
    nlit = 0;
    for (int f = 0; f < 8; f++) begin
      step();
      lit[f] = (an_n == 4'hE);
      if (lit[f]) nlit++;
      for (int j = 2; j <= 16; j++) begin
        step();
        if (j == 13) chk("blink_d3_an", an_n, 4'h7);
      end
    end
    for (int f = 0; f < 6; f++) chk("blink_period", lit[f + 2], !lit[f]);
    chk("blink_count", nlit, 4);
    blink_mask = 4'b0000;
`endif

    // Randomized traffic against the reference model
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 9) == 0) digits = 16'($urandom);
      if ($urandom_range(0, 9) == 0) dp_in = 4'($urandom);
      if ($urandom_range(0, 19) == 0) lz_blank = 1'($urandom);
      if ($urandom_range(0, 15) == 0) en = 1'($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) digits[15:8] = 8'h00;
`ifdef SEG7_BLINK_EN
      if ($urandom_range(0, 19) == 0) blink_mask = 4'($urandom);
`endif
      if (i == 250) begin
        #3 rst_n = 1'b0;
        #1 chk("rnd_rst_an", an_n, 4'hF);
        rst_n = 1'b1;
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
